pause_fade: RTL and testbench
=============================

PAUSE_FADE -- requirements
Module: pause_fade

Interface
REQ-001 Parameter RW, default 8, red channel width.
REQ-002 Parameter GW, default 8, green channel width.
REQ-003 Parameter BW, default 8, blue channel width.
REQ-004 Parameter NREQ, default 2, number of external pause-request lines (1..8).
REQ-005 Parameter CLKSPD, default 12, clk_sys frequency in MHz.
REQ-006 Parameter TICK_CYCLES, default CLKSPD*125000, clk_sys cycles per eighth-second tick.
REQ-007 Parameter DIM_SECONDS, default 10, paused time before dimming starts.
REQ-008 Parameter MAX_DIM, default 2, maximum right-shift dim level (1..3).
REQ-009 clk_sys  in  1  core system clock; only clock.
REQ-010 reset_n  in  1  asynchronous, active-low reset.
REQ-011 core_reset  in  1  active-high core/CPU reset; cancels user pause.
REQ-012 user_button  in  1  pause toggle button, active-high.
REQ-013 step_button  in  1  single-frame-advance button, active-high.
REQ-014 pause_request  in  NREQ  per-source pause requests, active-high.
REQ-015 options  in  3  [0] pause in OSD, [1] dim enable, [2] frame-aligned pause.
REQ-016 OSD_STATUS  in  1  OSD open, active-high.
REQ-017 vblank  in  1  core vertical blank, active-high, clk_sys-synchronous.
REQ-018 r / g / b  in  RW / GW / BW  video from core.
REQ-019 pause_cpu  out  1  CPU halt, active-high.
REQ-020 rgb_out  out  RW+GW+BW  {r,g,b} after dimming, registered.
REQ-021 dim_level  out  2  current dim shift (0..MAX_DIM).

Function
REQ-022 want = user_pause | (|pause_request) | (OSD_STATUS & options[0]).
REQ-023 user_pause SHALL toggle on each user_button rising edge (registered edge detect); core_reset high SHALL clear it, clear wins over a same-cycle toggle.
REQ-024 FSM states: RUN, PENDING, PAUSED, STEP.
REQ-025 RUN: want=1 & options[2]=0 -> PAUSED; want=1 & options[2]=1 -> PENDING.
REQ-026 PENDING: vblank rising edge (vblank=1, previous vblank=0) -> PAUSED; want=0 -> RUN; want=0 takes priority.
REQ-027 PAUSED: want=0 -> RUN next cycle regardless of options[2].
REQ-028 PAUSED: step_button rising edge while user_pause=1, pause_request=0 and not (OSD_STATUS & options[0]) -> STEP; otherwise step ignored.
REQ-029 STEP: next vblank rising edge -> PAUSED; want=0 -> RUN (priority over vblank).
REQ-030 pause_cpu SHALL equal (state==PAUSED) & !core_reset, decoded from registered state, asserting one cycle after the qualifying transition condition.
REQ-031 Tick prescaler SHALL count 0..TICK_CYCLES-1 only while state==PAUSED & options[1], and clear otherwise.
REQ-032 Pause tick counter SHALL increment per tick, saturate at DIM_SECONDS*8, clear when prescaler clears.
REQ-033 On reaching DIM_SECONDS*8 ticks dim_level SHALL become 1, then increment by 1 per subsequent tick, saturating at MAX_DIM.
REQ-034 dim_level SHALL return to 0 in the cycle after leaving PAUSED or options[1] dropping.
REQ-035 rgb_out SHALL register {r>>dim_level, g>>dim_level, b>>dim_level} each cycle: one-cycle latency, zero fill, channels independent.
REQ-036 Counter widths SHALL hold TICK_CYCLES-1 and DIM_SECONDS*8 without overflow.

Reset
REQ-037 reset_n low SHALL asynchronously force state=RUN, user_pause=0, edge-detect registers=0, counters=0, dim_level=0, rgb_out=0, pause_cpu=0.
REQ-038 core_reset SHALL not reset the FSM but SHALL gate pause_cpu low and clear user_pause; external requests persist.

Verification (TICK_CYCLES=4, DIM_SECONDS=1, MAX_DIM=2, NREQ=2)
REQ-039 options=0, user_button pulse -> pause_cpu=1 one cycle after the edge; second pulse -> pause_cpu=0 one cycle after.
REQ-040 options[2]=1, pause_request=2'b01 mid-frame -> pause_cpu stays 0 until vblank 0->1, then 1 next cycle; request dropped before vblank -> never asserts.
REQ-041 options[1]=1, paused with r=8'hF0 -> rgb_out=F0 for 32 cycles, then 78 (level 1), 4 cycles later 3C (level 2), remains 3C; unpause -> F0 one cycle after dim_level clears.
REQ-042 User-paused, step_button pulse -> pause_cpu=0 until next vblank rising edge, then 1; same with pause_request=2'b10 active -> step ignored, pause_cpu stays 1.
REQ-043 User-paused, core_reset pulse -> pause_cpu=0 immediately, user_pause cleared, FSM returns to RUN next cycle.
REQ-044 reset_n asserted mid-dim (dim_level=2) -> all outputs 0 without a clock edge; after release, state RUN.

Source files
------------

// File: rtl/pause_fade.sv
// Pause controller with frame-aligned halting, single-frame step and idle screen dimming.
`default_nettype none

module pause_fade #(
  parameter int RW          = 8,
  parameter int GW          = 8,
  parameter int BW          = 8,
  parameter int NREQ        = 2,
  parameter int CLKSPD      = 12,
  parameter int TICK_CYCLES = CLKSPD * 125000,
  parameter int DIM_SECONDS = 10,
  parameter int MAX_DIM     = 2
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  core_reset,
  input  logic                  user_button,
  input  logic                  step_button,
  input  logic [NREQ-1:0]       pause_request,
  input  logic [2:0]            options,
  input  logic                  OSD_STATUS,
  input  logic                  vblank,
  input  logic [RW-1:0]         r,
  input  logic [GW-1:0]         g,
  input  logic [BW-1:0]         b,
  output logic                  pause_cpu,
  output logic [RW+GW+BW-1:0]   rgb_out,
  output logic [1:0]            dim_level
);

  localparam int DIM_TICKS = DIM_SECONDS * 8;
  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int TW = (DIM_TICKS > 0) ? $clog2(DIM_TICKS + 1) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LIMIT = TW'(DIM_TICKS);
  localparam logic [TW-1:0] TICK_PRE   = TW'(DIM_TICKS - 1);
  localparam logic [1:0]    DIM_MAX    = 2'(MAX_DIM);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PENDING = 2'd1,
    PAUSED  = 2'd2,
    STEP    = 2'd3
  } state_t;

  state_t          state;
  logic            user_pause;
  logic            user_q;
  logic            step_q;
  logic            vblank_q;
  logic [PW-1:0]   presc;
  logic [TW-1:0]   ticks;

  logic osd_hold;
  logic ext_req;
  logic want;
  logic user_rise;
  logic step_rise;
  logic vblank_rise;
  logic step_ok;
  logic dim_active;

  assign osd_hold    = OSD_STATUS & options[0];
  assign ext_req     = |pause_request;
  assign want        = user_pause | ext_req | osd_hold;
  assign user_rise   = user_button & ~user_q;
  assign step_rise   = step_button & ~step_q;
  assign vblank_rise = vblank & ~vblank_q;
  // Stepping only makes sense when the user alone is holding the pause.
  assign step_ok     = step_rise & user_pause & ~ext_req & ~osd_hold;
  assign dim_active  = (state == PAUSED) & options[1];

  assign pause_cpu = (state == PAUSED) & ~core_reset;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RUN;
      user_pause <= 1'b0;
      user_q     <= 1'b0;
      step_q     <= 1'b0;
      vblank_q   <= 1'b0;
    end else begin
      user_q   <= user_button;
      step_q   <= step_button;
      vblank_q <= vblank;

      if (core_reset)
        user_pause <= 1'b0;
      else if (user_rise)
        user_pause <= ~user_pause;

      case (state)
        RUN: begin
          if (want)
            state <= options[2] ? PENDING : PAUSED;
        end
        PENDING: begin
          if (!want)
            state <= RUN;
          else if (vblank_rise)
            state <= PAUSED;
        end
        PAUSED: begin
          if (!want)
            state <= RUN;
          else if (step_ok)
            state <= STEP;
        end
        STEP: begin
          if (!want)
            state <= RUN;
          else if (vblank_rise)
            state <= PAUSED;
        end
        default: state <= RUN;
      endcase
    end
  end

  // The eighth-second prescaler and tick count only run while dimming is possible.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      presc     <= '0;
      ticks     <= '0;
      dim_level <= 2'd0;
    end else if (!dim_active) begin
      presc     <= '0;
      ticks     <= '0;
      dim_level <= 2'd0;
    end else if (presc == PRESC_MAX) begin
      presc <= '0;
      if (ticks != TICK_LIMIT) begin
        ticks <= ticks + 1'b1;
        if (ticks == TICK_PRE)
          dim_level <= 2'd1;
      end else if (dim_level != DIM_MAX) begin
        dim_level <= dim_level + 2'd1;
      end
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)
      rgb_out <= '0;
    else
      rgb_out <= {r >> dim_level, g >> dim_level, b >> dim_level};
  end

endmodule

`default_nettype wire

// File: tb/tb_pause_fade.sv
// Directed self-checking bench for pause_fade using small tick parameters.
`default_nettype none

module tb_pause_fade;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        core_reset;
  logic        user_button;
  logic        step_button;
  logic [1:0]  pause_request;
  logic [2:0]  options;
  logic        OSD_STATUS;
  logic        vblank;
  logic [7:0]  r, g, b;
  logic        pause_cpu;
  logic [23:0] rgb_out;
  logic [1:0]  dim_level;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic [23:0] exp;
  } vec_t;

  vec_t lvl0[3];
  vec_t lvl2[3];

  pause_fade #(
    .RW(8), .GW(8), .BW(8), .NREQ(2), .CLKSPD(12),
    .TICK_CYCLES(4), .DIM_SECONDS(1), .MAX_DIM(2)
  ) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .core_reset    (core_reset),
    .user_button   (user_button),
    .step_button   (step_button),
    .pause_request (pause_request),
    .options       (options),
    .OSD_STATUS    (OSD_STATUS),
    .vblank        (vblank),
    .r             (r),
    .g             (g),
    .b             (b),
    .pause_cpu     (pause_cpu),
    .rgb_out       (rgb_out),
    .dim_level     (dim_level)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press_user();
    user_button = 1'b1;
    tick();
    user_button = 1'b0;
    tick();
  endtask

  initial begin
    int k;

    lvl0[0] = '{8'hF0, 8'h0F, 8'hA5, 24'hF00FA5};
    lvl0[1] = '{8'hFF, 8'hFF, 8'hFF, 24'hFFFFFF};
    lvl0[2] = '{8'h01, 8'h80, 8'h7E, 24'h01807E};
    lvl2[0] = '{8'hFF, 8'hFF, 8'hFF, 24'h3F3F3F};
    lvl2[1] = '{8'hF0, 8'h0F, 8'hA5, 24'h3C0329};
    lvl2[2] = '{8'h01, 8'h80, 8'h7E, 24'h00201F};

    reset_n = 1'b0; core_reset = 1'b0; user_button = 1'b0; step_button = 1'b0;
    pause_request = 2'b00; options = 3'b000; OSD_STATUS = 1'b0; vblank = 1'b0;
    r = 8'hAA; g = 8'h55; b = 8'h11;
    tick(); tick();
    check("reset_pause_cpu", {31'd0, pause_cpu}, 0);
    check("reset_rgb_out", {8'd0, rgb_out}, 0);
    check("reset_dim_level", {30'd0, dim_level}, 0);
    reset_n = 1'b1;
    tick();

    // User toggle: pause one cycle after the edge is registered, then release.
    user_button = 1'b1;
    tick();
    check("user_edge_not_yet", {31'd0, pause_cpu}, 0);
    user_button = 1'b0;
    tick();
    check("user_pause_on", {31'd0, pause_cpu}, 1);
    user_button = 1'b1;
    tick();
    check("user_second_edge_hold", {31'd0, pause_cpu}, 1);
    user_button = 1'b0;
    tick();
    check("user_pause_off", {31'd0, pause_cpu}, 0);

    for (int i = 0; i < 3; i++) begin
      r = lvl0[i].r; g = lvl0[i].g; b = lvl0[i].b;
      tick();
      check($sformatf("rgb_lvl0_%0d", i), {8'd0, rgb_out}, {8'd0, lvl0[i].exp});
    end

    // Frame-aligned pause waits for a vblank rising edge.
    options = 3'b100;
    pause_request = 2'b01;
    tick(); tick(); tick();
    check("aligned_wait", {31'd0, pause_cpu}, 0);
    vblank = 1'b1;
    tick();
    check("aligned_vblank_pause", {31'd0, pause_cpu}, 1);
    vblank = 1'b0;
    pause_request = 2'b00;
    tick();
    check("aligned_release", {31'd0, pause_cpu}, 0);
    pause_request = 2'b01;
    tick(); tick();
    pause_request = 2'b00;
    tick();
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    tick();
    check("aligned_cancel", {31'd0, pause_cpu}, 0);

    // Dimming: 8 ticks of 4 cycles before level 1, then one level per tick.
    options = 3'b010;
    r = 8'hF0; g = 8'h00; b = 8'h00;
    pause_request = 2'b01;
    tick();
    check("dim_paused", {31'd0, pause_cpu}, 1);
    k = 0;
    while (dim_level == 2'd0 && k < 100) begin
      tick();
      k++;
    end
    check("dim_start_cycle", k, 32);
    check("dim_rgb_before", {8'd0, rgb_out}, 32'h00F00000);
    tick();
    check("dim_rgb_level1", {8'd0, rgb_out}, 32'h00780000);
    tick(); tick(); tick();
    check("dim_level2", {30'd0, dim_level}, 2);
    tick();
    check("dim_rgb_level2", {8'd0, rgb_out}, 32'h003C0000);
    for (int i = 0; i < 3; i++) begin
      r = lvl2[i].r; g = lvl2[i].g; b = lvl2[i].b;
      tick();
      check($sformatf("rgb_lvl2_%0d", i), {8'd0, rgb_out}, {8'd0, lvl2[i].exp});
    end
    r = 8'hF0; g = 8'h00; b = 8'h00;
    for (int i = 0; i < 8; i++) tick();
    check("dim_saturate", {30'd0, dim_level}, 2);
    check("dim_rgb_hold", {8'd0, rgb_out}, 32'h003C0000);
    pause_request = 2'b00;
    tick();
    check("undim_unpaused", {31'd0, pause_cpu}, 0);
    tick();
    check("undim_level0", {30'd0, dim_level}, 0);
    check("undim_rgb_lag", {8'd0, rgb_out}, 32'h003C0000);
    tick();
    check("undim_rgb", {8'd0, rgb_out}, 32'h00F00000);

    // Single-frame step from a user pause.
    options = 3'b000;
    press_user();
    check("step_paused", {31'd0, pause_cpu}, 1);
    step_button = 1'b1;
    tick();
    step_button = 1'b0;
    check("step_running", {31'd0, pause_cpu}, 0);
    tick(); tick();
    check("step_still_running", {31'd0, pause_cpu}, 0);
    vblank = 1'b1;
    tick();
    check("step_repaused", {31'd0, pause_cpu}, 1);
    vblank = 1'b0;
    tick();
    pause_request = 2'b10;
    tick();
    step_button = 1'b1;
    tick();
    step_button = 1'b0;
    tick();
    check("step_ignored_req", {31'd0, pause_cpu}, 1);
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    check("step_ignored_vblank", {31'd0, pause_cpu}, 1);
    pause_request = 2'b00;
    tick();
    check("step_user_holds", {31'd0, pause_cpu}, 1);

    // Core reset gates pause_cpu at once and cancels the user pause.
    core_reset = 1'b1;
    #1;
    check("core_reset_gate", {31'd0, pause_cpu}, 0);
    tick(); tick();
    core_reset = 1'b0;
    #1;
    check("core_reset_run", {31'd0, pause_cpu}, 0);
    tick();
    check("core_reset_stays_run", {31'd0, pause_cpu}, 0);
    press_user();
    check("core_reset_toggle_fresh", {31'd0, pause_cpu}, 1);
    press_user();
    check("core_reset_toggle_off", {31'd0, pause_cpu}, 0);

    // Asynchronous reset in the middle of a dimmed pause.
    options = 3'b010;
    pause_request = 2'b01;
    for (int i = 0; i < 45; i++) tick();
    check("mid_dim_level", {30'd0, dim_level}, 2);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_pause_cpu", {31'd0, pause_cpu}, 0);
    check("async_rgb", {8'd0, rgb_out}, 0);
    check("async_dim", {30'd0, dim_level}, 0);
    pause_request = 2'b00;
    options = 3'b000;
    tick();
    reset_n = 1'b1;
    tick();
    check("post_reset_run", {31'd0, pause_cpu}, 0);
    press_user();
    check("post_reset_pause", {31'd0, pause_cpu}, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
